// File: rtl/mfp_ahb_master_pkg.sv
// ---------------------------------------------------------------------------
// mfp_ahb_master_pkg
// Shared definitions for the AHB-Lite initiator port:
//   - state_e     : controller states (IDLE / ADDR / DATA)
//   - HTRANS_*    : AHB transfer-type encodings
//   - HSIZE_*     : AHB transfer-size encodings
//   - HBURST_*    : AHB burst encodings (only SINGLE is ever issued)
//   - HPROT_*     : protection attribute driven on every transfer
//   - cmd_is_legal: size / alignment check applied to incoming commands
// Encodings match the values of the mfp_ahb_lite.vh macros.
// ---------------------------------------------------------------------------
package mfp_ahb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Data access, privileged, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // A command is legal when its size fits a 32-bit bus and the address
    // is naturally aligned to that size.
    function automatic logic cmd_is_legal(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_lite_master_timeout.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_timeout
// Saturating wait-state counter for the data phase of the AHB initiator.
// Only instantiated when MFP_AHB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk     : bus clock
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear (held while the initiator is not in DATA)
//   en      : count one wait state (DATA with HREADY low)
//   expired : count has reached LIMIT
// Counter width is sized from LIMIT and clamped to 8..16 bits.
// ---------------------------------------------------------------------------
module ahb_lite_master_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int RAW_W = $clog2(LIMIT + 1);
    localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q >= LIMIT_C);

    // Stops at the limit so the count can never wrap back below it.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ahb_lite_master_port.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_port
// Single-outstanding AHB-Lite initiator. Each accepted valid/ready command
// becomes one SINGLE transfer; exactly one response pulse is returned.
// Ports:
//   HCLK, HRESETn                : clock, async active-low reset
//   cmd_valid/ready/write/addr/size/wdata : command input port
//   rsp_valid/err/rdata          : registered one-cycle response
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HBURST/HPROT/HMASTLOCK : AHB outputs
//   HRDATA/HREADY/HRESP          : AHB inputs
// Optional feature: define MFP_AHB_MASTER_TIMEOUT_EN to abort a data phase
// after TIMEOUT_CYCLES consecutive wait states.
// ---------------------------------------------------------------------------
module ahb_lite_master_port
    import mfp_ahb_master_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH    = 32,
    parameter int unsigned HDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [HADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]             cmd_size,
    input  logic [HDATA_WIDTH-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [HDATA_WIDTH-1:0] rsp_rdata,
    output logic [HADDR_WIDTH-1:0] HADDR,
    output logic [1:0]             HTRANS,
    output logic [2:0]             HSIZE,
    output logic                   HWRITE,
    output logic [HDATA_WIDTH-1:0] HWDATA,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic                   HMASTLOCK,
    input  logic [HDATA_WIDTH-1:0] HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP
);

    state_e                 state_q, state_d;
    logic                   write_q, write_d;
    logic [HADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]             size_q, size_d;
    logic [HDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [HDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   cmd_legal;
    logic                   timeout_expired;

    assign cmd_legal = cmd_is_legal(cmd_size, cmd_addr[1:0]);

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    // Held clear outside DATA, so the count starts at zero on DATA entry.
    ahb_lite_master_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .clr     (state_q != ST_DATA),
        .en      ((state_q == ST_DATA) && !HREADY),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_legal) state_d = ST_ADDR;
            ST_ADDR: if (HREADY) state_d = ST_DATA;
            // A completing HREADY wins over a timeout in the same cycle.
            ST_DATA: if (HREADY || timeout_expired) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch and response generation
    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    wdata_d = cmd_wdata;
                    // Illegal commands are answered directly, bus untouched.
                    if (!cmd_legal) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!write_q && !HRESP) ? HRDATA : '0;
                end else if (timeout_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: decoded from registered state and latched command only
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWDATA    = ((state_q == ST_DATA) && write_q) ? wdata_q : '0;
    end

    assign HADDR     = addr_q;
    assign HSIZE     = size_q;
    assign HWRITE    = write_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master_port
// Self-checking bench for ahb_lite_master_port. The bench plays the AHB
// slave and predicts each response from command/slave behaviour alone.
// Honours MFP_AHB_MASTER_TIMEOUT_EN for the stuck-HREADY scenario.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master_port;

    localparam int TMO = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    ahb_lite_master_port #(
        .HADDR_WIDTH    (32),
        .HDATA_WIDTH    (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;      // data-phase wait states before completion
        logic        slv_err;    // slave answers with two-cycle ERROR
        logic [31:0] slv_rdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;    // cycle of rsp_valid, accept edge = cycle 0
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Reference rules for a command, independent of any implementation.
    function automatic logic ref_legal(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b0;
        return (addr % (32'd1 << size)) == 32'd0;
    endfunction

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] wd, input int waits, input logic se,
                                input logic [31:0] rd, input logic ee, input logic [31:0] er,
                                input int lat);
        vec_t v;
        v.write = w; v.addr = a; v.size = s; v.wdata = wd; v.waits = waits;
        v.slv_err = se; v.slv_rdata = rd; v.exp_err = ee; v.exp_rdata = er; v.exp_lat = lat;
        return v;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic ok = ref_legal(v.size, v.addr);
        r.exp_err   = !ok || v.slv_err;
        r.exp_rdata = (ok && !v.write && !v.slv_err) ? v.slv_rdata : 32'd0;
        r.exp_lat   = ok ? (3 + v.waits + (v.slv_err ? 1 : 0)) : 1;
        return r;
    endfunction

    // Issue one command, act as slave, check bus activity and response.
    task automatic run_vec(input vec_t v, input string tag);
        int  rsp_cyc = -1;
        int  nonseq_cnt = 0;
        int  nonseq_cyc = -1;
        int  dk = 0;
        bit  data_next = 0;
        bit  in_data = 0;
        bit  last_data;
        bit  ok = ref_legal(v.size, v.addr);

        check({tag, " ready_idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_size = v.size; cmd_wdata = v.wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        step();
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom;
        cmd_size = 3'($urandom); cmd_wdata = $urandom;
        for (int c = 1; c <= v.exp_lat + 8; c++) begin
            if (data_next) begin in_data = 1; data_next = 0; end
            if (rsp_valid) begin
                rsp_cyc = c;
                check({tag, " rsp_err"}, rsp_err, v.exp_err);
                check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
                check({tag, " ready_at_rsp"}, cmd_ready, 1);
                check({tag, " htrans_at_rsp"}, HTRANS, 2'b00);
                break;
            end
            if (HTRANS == 2'b10) begin
                nonseq_cnt++;
                nonseq_cyc = c;
                check({tag, " haddr"}, HADDR, v.addr);
                check({tag, " hsize"}, HSIZE, v.size);
                check({tag, " hwrite"}, HWRITE, v.write);
            end
            if (in_data) begin
                check({tag, " htrans_data"}, HTRANS, 2'b00);
                check({tag, " hwdata"}, HWDATA, v.write ? v.wdata : 32'd0);
                check({tag, " haddr_hold"}, HADDR, v.addr);
            end
            if (HTRANS == 2'b10 || in_data) check({tag, " ready_busy"}, cmd_ready, 0);
            HRDATA = $urandom; HREADY = 1'b1; HRESP = 1'b0; last_data = 0;
            if (in_data) begin
                if (dk < v.waits) HREADY = 1'b0;
                else if (v.slv_err && dk == v.waits) begin HREADY = 1'b0; HRESP = 1'b1; end
                else begin HRESP = v.slv_err; HRDATA = v.slv_rdata; last_data = 1; end
                dk++;
            end
            if (HTRANS == 2'b10) data_next = 1;
            if (last_data) in_data = 0;
            step();
        end
        if (rsp_cyc < 0) check({tag, " response_arrived"}, 0, 1);
        else             check({tag, " latency"}, rsp_cyc, v.exp_lat);
        check({tag, " nonseq_count"}, nonseq_cnt, ok ? 1 : 0);
        if (ok) check({tag, " nonseq_cycle"}, nonseq_cyc, 1);
        HREADY = 1'b1; HRESP = 1'b0;
        step();
        check({tag, " rsp_pulse_one_cycle"}, rsp_valid, 0);
        $display("txn %s: wr=%0d addr=0x%0h size=%0d waits=%0d err=%0d -> rsp cycle %0d err=%0d rdata=0x%0h",
                 tag, v.write, v.addr, v.size, v.waits, v.slv_err, rsp_cyc, rsp_err, rsp_rdata);
    endtask

    task automatic reset_pulse();
        HRESETn = 1'b0;
        step();
        step();
        HRESETn = 1'b1;
        step();
    endtask

    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk(1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,        3);
        tbl[1] = mk(0, 32'h103, 3'd0, 32'h0,        3, 0, 32'h11223344, 0, 32'h11223344, 6);
        tbl[2] = mk(0, 32'h101, 3'd1, 32'h0,        0, 0, 32'h0,        1, 32'h0,        1);
        tbl[3] = mk(0, 32'h200, 3'd2, 32'h0,        0, 1, 32'hCAFEF00D, 1, 32'h0,        4);
        tbl[4] = mk(0, 32'h204, 3'd2, 32'h0,        1, 0, 32'h55AA00FF, 0, 32'h55AA00FF, 4);
        tbl[5] = mk(1, 32'h0,   3'd3, 32'h1,        0, 0, 32'h0,        1, 32'h0,        1);
        tbl[6] = mk(1, 32'h102, 3'd1, 32'h12340000, 2, 0, 32'h0,        0, 32'h0,        5);
        tbl[7] = mk(0, 32'h102, 3'd2, 32'h0,        0, 0, 32'h0,        1, 32'h0,        1);
        tbl[8] = mk(1, 32'h300, 3'd2, 32'hA5A5A5A5, 1, 1, 32'h0,        1, 32'h0,        5);

        // Reset values
        #2 HRESETn = 1'b0;
        #2;
        check("reset cmd_ready", cmd_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset htrans", HTRANS, 2'b00);
        check("reset haddr", HADDR, 0);
        check("reset hsize", HSIZE, 0);
        check("reset hwrite", HWRITE, 0);
        check("reset hwdata", HWDATA, 0);
        check("hburst single", HBURST, 3'b000);
        check("hprot", HPROT, 4'b0011);
        check("hmastlock", HMASTLOCK, 0);
        step();
        step();
        HRESETn = 1'b1;
        step();

        // Directed table
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Randomized commands against the reference rules
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.write     = 1'($urandom);
            v.addr      = $urandom & 32'h0000_0FFF;
            v.size      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            v.wdata     = $urandom;
            v.waits     = $urandom_range(0, 2);
            v.slv_err   = ($urandom_range(0, 3) == 0);
            v.slv_rdata = $urandom;
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a data phase with HREADY low
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_size = 3'd2;
        cmd_wdata = 32'h0BADF00D; HREADY = 1'b1;
        step();                                // cycle 1: ADDR
        cmd_valid = 1'b0;
        check("midrst nonseq", HTRANS, 2'b10);
        step();                                // cycle 2: DATA
        HREADY = 1'b0;
        check("midrst in_data hwdata", HWDATA, 32'h0BADF00D);
        step();                                // cycle 3: still DATA
        #2 HRESETn = 1'b0;
        #1;
        check("midrst htrans", HTRANS, 2'b00);
        check("midrst rsp_valid", rsp_valid, 0);
        check("midrst haddr", HADDR, 0);
        check("midrst hwdata", HWDATA, 0);
        check("midrst cmd_ready", cmd_ready, 1);
        HREADY = 1'b1;
        step();
        HRESETn = 1'b1;
        step();
        check("midrst ready_after", cmd_ready, 1);
        check("midrst no_rsp", rsp_valid, 0);
        $display("txn midrst: reset during DATA, outputs returned to idle");
        run_vec(tbl[0], "after_midrst");

        // Data phase with HREADY stuck low
        begin
            int rsp_cyc = -1;
            logic got_err = 1'b0;
            logic [31:0] got_rd = '0;
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_size = 3'd2;
            HREADY = 1'b1;
            step();                            // cycle 1: ADDR
            cmd_valid = 1'b0;
            check("hang nonseq", HTRANS, 2'b10);
            step();                            // cycle 2: DATA entry
            HREADY = 1'b0;
            for (int c = 2; c <= 30; c++) begin
                if (rsp_valid && rsp_cyc < 0) begin
                    rsp_cyc = c; got_err = rsp_err; got_rd = rsp_rdata;
                end
                if (c > 1 && HTRANS == 2'b10) check("hang no_new_nonseq", HTRANS, 2'b00);
                step();
            end
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
            check("timeout rsp_cycle", rsp_cyc, 2 + TMO + 1);
            check("timeout rsp_err", got_err, 1);
            check("timeout rsp_rdata", got_rd, 0);
            check("timeout ready", cmd_ready, 1);
            $display("txn timeout: rsp cycle %0d err=%0d", rsp_cyc, got_err);
            HREADY = 1'b1;
            step();
`else
            check("hang no_response", rsp_cyc, -1);
            check("hang still_busy", cmd_ready, 0);
            $display("txn hang: no response after 30 cycles, resetting");
            HREADY = 1'b1;
            reset_pulse();
`endif
            check("hang recovered_ready", cmd_ready, 1);
        end
        run_vec(tbl[1], "after_hang");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
